aq_djpeg_rgb_writer: RTL

Consumes the RGB pixel stream from the YCbCr→RGB converter: pixel X/Y plus 8-bit R/G/B under an enable/ready handshake. Drops pixels that fall in MCU padding outside the image, and converts each remaining pixel into a frame-buffer memory write request with a computed byte address. A 4-entry FIFO absorbs memory back-pressure, which is returned upstream as ready. It raises a one-cycle frame-done pulse after the last in-image pixel write is accepted.

---
 rtl/aq_djpeg_pkg.sv | 45 ++++
 rtl/aq_djpeg_sfifo.sv | 89 ++++++++
 rtl/aq_djpeg_rgb_writer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aq_djpeg_pkg.sv
// -----------------------------------------------------------------------------
// aq_djpeg_pkg
// Shared constants and types for the JPEG decoder RGB output path.
//   - Write-request payload layout (address, data, byte strobes).
//   - Default depth of the write-request FIFO.
//   - RGB565 field positions and a packing helper, used when the block is
//     built with AQ_DJPEG_RGB565_EN defined.
// -----------------------------------------------------------------------------
package aq_djpeg_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STRB_W     = 4;
   // 32 addr + 32 data + 4 strobe = 68 bits per queued request
   localparam int PAYLOAD_W  = ADDR_W + DATA_W + STRB_W;

   localparam int DEFAULT_FIFO_DEPTH = 4;

   // RGB565 layout: {R[7:3], G[7:2], B[7:3]}
   localparam int RGB565_R_LSB = 11;
   localparam int RGB565_R_W   = 5;
   localparam int RGB565_G_LSB = 5;
   localparam int RGB565_G_W   = 6;
   localparam int RGB565_B_LSB = 0;
   localparam int RGB565_B_W   = 5;

   // Field order matches the flat FIFO word: addr in the top bits, strobes last.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } wrReq_t;

   function automatic logic [15:0] packRgb565(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      p[RGB565_R_LSB +: RGB565_R_W] = r[7 -: RGB565_R_W];
      p[RGB565_G_LSB +: RGB565_G_W] = g[7 -: RGB565_G_W];
      p[RGB565_B_LSB +: RGB565_B_W] = b[7 -: RGB565_B_W];
      return p;
   endfunction

endpackage

// File: rtl/aq_djpeg_sfifo.sv
// -----------------------------------------------------------------------------
// aq_djpeg_sfifo
// Small synchronous FIFO with first-word-fall-through read: popData always
// shows the head entry. Storage is a register per entry so the head reads as
// zero straight out of reset.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2)
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous empty (pointers and count cleared)
//   push, pushData    write an entry (ignored when full and not popping)
//   pop               drop the head entry (ignored when empty)
//   popData           head entry
//   count             number of stored entries (0..DEPTH)
//   empty, full       status flags
// -----------------------------------------------------------------------------
module aq_djpeg_sfifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wrPtr_reg;
   logic [AW-1:0]    rdPtr_reg;
   logic [AW:0]      count_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             doPush;
   logic             doPop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == (AW+1)'(DEPTH));

   // A push into a full FIFO is allowed when the head leaves in the same cycle.
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mem[gi] <= '0;
            end else if (doPush && !flush && (wrPtr_reg == AW'(gi))) begin
               mem[gi] <= pushData;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_reg <= '0;
         rdPtr_reg <= '0;
         count_reg <= '0;
      end else if (flush) begin
         wrPtr_reg <= '0;
         rdPtr_reg <= '0;
         count_reg <= '0;
      end else begin
         if (doPush) begin
            wrPtr_reg <= wrPtr_reg + 1'b1;
         end
         if (doPop) begin
            rdPtr_reg <= rdPtr_reg + 1'b1;
         end
         if (doPush && !doPop) begin
            count_reg <= count_reg + 1'b1;
         end else if (doPop && !doPush) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   assign popData = mem[rdPtr_reg];
   assign count   = count_reg;

endmodule

// File: rtl/aq_djpeg_rgb_writer.sv
// -----------------------------------------------------------------------------
// aq_djpeg_rgb_writer
// Turns the decoder's RGB pixel stream into frame-buffer write requests.
// Pixels in MCU padding (outside ImageWidth x ImageHeight) are dropped; the
// rest get a byte address from their X/Y and go through a registered stage
// (S1) into a small request FIFO whose head drives the memory port directly.
// Upstream ready is credit based: S1 plus FIFO occupancy never exceeds the
// FIFO depth, so a push from S1 can always be taken. A one-cycle FrameDone
// follows the write handshake that completes ImageWidth*ImageHeight pixels.
//
// Build option:
//   AQ_DJPEG_RGB565_EN  undefined: xRGB888, one pixel per 32-bit word
//                       defined  : RGB565, two bytes per pixel, half-word
//                                  strobes, data duplicated in both halves
//
// Parameters: FIFO_DEPTH  request FIFO entries (power of 2, >= 2)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   DataInit                 synchronous flush / start of a new image
//   ImageWidth, ImageHeight  visible image size in pixels
//   BaseAddress              byte address of pixel (0,0)
//   PixEnable, PixReady      pixel handshake
//   PixX, PixY, PixR/G/B     pixel coordinates and colour
//   WrValid, WrReady         write request handshake
//   WrAddr, WrData, WrStrb   write request payload
//   FrameDone                one-cycle end-of-image pulse
// -----------------------------------------------------------------------------
module aq_djpeg_rgb_writer
   import aq_djpeg_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DataInit,
   input  logic [15:0] ImageWidth,
   input  logic [15:0] ImageHeight,
   input  logic [31:0] BaseAddress,
   input  logic        PixEnable,
   output logic        PixReady,
   input  logic [15:0] PixX,
   input  logic [15:0] PixY,
   input  logic [7:0]  PixR,
   input  logic [7:0]  PixG,
   input  logic [7:0]  PixB,
   output logic        WrValid,
   input  logic        WrReady,
   output logic [31:0] WrAddr,
   output logic [31:0] WrData,
   output logic [3:0]  WrStrb,
   output logic        FrameDone
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          run_reg;
   logic          inImage;
   logic          pixAccept;
   logic [31:0]   pixIdx;
   logic [31:0]   totalPix;
   wrReq_t        reqNext;
   wrReq_t        s1Req_reg;
   logic          s1Valid_reg;
   wrReq_t        headReq;
   logic [CW-1:0] fifoCount;
   logic [CW:0]   inFlight;
   logic          fifoEmpty;
   logic          fifoFull;
   logic          wrPop;
   logic [31:0]   pixCount_reg;
   logic          frameDone_reg;

   // Held low through reset and rises on the first clock afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_reg <= 1'b0;
      end else begin
         run_reg <= 1'b1;
      end
   end

   // Credits: everything already past the input (S1 + FIFO) must fit in the FIFO.
   assign inFlight  = {1'b0, fifoCount} + {{CW{1'b0}}, s1Valid_reg};
   assign PixReady  = run_reg && !DataInit && !fifoFull &&
                      (inFlight < (CW+1)'(FIFO_DEPTH));
   assign pixAccept = PixEnable && PixReady;

   // A zero width or height makes every pixel fall outside the image.
   assign inImage   = (PixX < ImageWidth) && (PixY < ImageHeight);

   // 16x16 product fits exactly in 32 bits; the add wraps modulo 2^32.
   assign pixIdx    = ({16'h0000, PixY} * {16'h0000, ImageWidth}) + {16'h0000, PixX};
   assign totalPix  = {16'h0000, ImageWidth} * {16'h0000, ImageHeight};

`ifdef AQ_DJPEG_RGB565_EN
   logic [15:0] rgb565;

   always_comb begin
      rgb565       = packRgb565(PixR, PixG, PixB);
      reqNext      = '0;
      reqNext.addr = BaseAddress + {pixIdx[30:0], 1'b0};
      reqNext.data = {rgb565, rgb565};
      // Pick the half-word lane the pixel lands in.
      reqNext.strb = reqNext.addr[1] ? 4'b1100 : 4'b0011;
   end
`else
   always_comb begin
      reqNext      = '0;
      reqNext.addr = BaseAddress + {pixIdx[29:0], 2'b00};
      reqNext.data = {8'h00, PixR, PixG, PixB};
      reqNext.strb = 4'hF;
   end
`endif

   // S1: one registered slot between the pixel port and the FIFO. It is
   // emptied every cycle because its push can never be refused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_reg <= 1'b0;
         s1Req_reg   <= '0;
      end else if (DataInit) begin
         s1Valid_reg <= 1'b0;
      end else begin
         s1Valid_reg <= pixAccept && inImage;
         if (pixAccept && inImage) begin
            s1Req_reg <= reqNext;
         end
      end
   end

   assign wrPop = WrValid && WrReady;

   aq_djpeg_sfifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (DataInit),
      .push     (s1Valid_reg && !DataInit),
      .pushData (s1Req_reg),
      .pop      (wrPop && !DataInit),
      .popData  (headReq),
      .count    (fifoCount),
      .empty    (fifoEmpty),
      .full     (fifoFull)
   );

   assign WrValid = !fifoEmpty;
   assign WrAddr  = headReq.addr;
   assign WrData  = headReq.data;
   assign WrStrb  = headReq.strb;

   // Counts completed writes; wraps to zero at the end of the image and
   // flags FrameDone for the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pixCount_reg  <= '0;
         frameDone_reg <= 1'b0;
      end else if (DataInit) begin
         pixCount_reg  <= '0;
         frameDone_reg <= 1'b0;
      end else if (wrPop) begin
         if ((pixCount_reg + 32'd1) == totalPix) begin
            pixCount_reg  <= '0;
            frameDone_reg <= 1'b1;
         end else begin
            pixCount_reg  <= pixCount_reg + 32'd1;
            frameDone_reg <= 1'b0;
         end
      end else begin
         frameDone_reg <= 1'b0;
      end
   end

   // A flush in the pulse cycle suppresses the pulse.
   assign FrameDone = frameDone_reg && !DataInit;

endmodule
